// File: rtl/combo_lock_pkg.sv
// Shared state encoding and width helpers for the combination lock core.
package combo_lock_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_LOCKED   = 3'd0;
  localparam logic [STATE_W-1:0] ST_CHECK    = 3'd1;
  localparam logic [STATE_W-1:0] ST_UNLOCKED = 3'd2;
  localparam logic [STATE_W-1:0] ST_PROGRAM  = 3'd3;
  localparam logic [STATE_W-1:0] ST_LOCKOUT  = 3'd4;

  typedef enum logic [STATE_W-1:0] {
    S_LOCKED   = ST_LOCKED,
    S_CHECK    = ST_CHECK,
    S_UNLOCKED = ST_UNLOCKED,
    S_PROGRAM  = ST_PROGRAM,
    S_LOCKOUT  = ST_LOCKOUT
  } state_e;

  // Bits needed to hold a count running from 0 up to max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/digit_selector.sv
// Wrap-around up/down digit counter with a synchronous clear that wins over counting.
module digit_selector #(
  parameter int DIGIT_W = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               en_i,
  input  logic               inc_i,
  input  logic               dec_i,
  input  logic               clear_i,
  output logic [DIGIT_W-1:0] digit_o
);

  logic [DIGIT_W-1:0] digit_q, digit_d;

  always_comb begin
    digit_d = digit_q;
    if (clear_i) begin
      digit_d = '0;
    end else if (en_i && inc_i && !dec_i) begin
      digit_d = digit_q + DIGIT_W'(1);
    end else if (en_i && dec_i && !inc_i) begin
      digit_d = digit_q - DIGIT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit_o = digit_q;

endmodule

// File: rtl/combo_lock_core.sv
// Combination lock: digit entry, code compare, reprogramming, failed-attempt
// counting and a timed lockout, all in one synchronous core.
module combo_lock_core
  import combo_lock_pkg::*;
#(
  parameter int                             NUM_DIGITS     = 4,
  parameter int                             DIGIT_W        = 4,
  parameter logic [NUM_DIGITS*DIGIT_W-1:0]  DEFAULT_CODE   = 16'h1234,
  parameter int                             MAX_TRIES      = 3,
  parameter int                             LOCKOUT_CYCLES = 100_000_000,
  localparam int ENTRY_W = NUM_DIGITS * DIGIT_W,
  localparam int CNT_W   = cnt_width(NUM_DIGITS),
  localparam int FAIL_W  = cnt_width(MAX_TRIES)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               inc_i,
  input  logic               dec_i,
  input  logic               enter_i,
  input  logic               clear_i,
  input  logic               lock_req_i,
  input  logic               prog_i,
  output logic [DIGIT_W-1:0] cur_digit_o,
  output logic [ENTRY_W-1:0] entry_o,
  output logic [CNT_W-1:0]   digit_cnt_o,
  output logic [FAIL_W-1:0]  fails_o,
  output logic [STATE_W-1:0] state_o,
  output logic               unlocked_o,
  output logic               alarm_o
);

  localparam int TMR_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(NUM_DIGITS - 1);
  localparam logic [FAIL_W-1:0] FAIL_LAST = FAIL_W'(MAX_TRIES - 1);
  localparam logic [FAIL_W-1:0] FAIL_MAX  = FAIL_W'(MAX_TRIES);
  localparam logic [TMR_W-1:0]  TMR_INIT  = TMR_W'(LOCKOUT_CYCLES - 1);

  state_e             state_q;
  logic [ENTRY_W-1:0] entry_q, code_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [FAIL_W-1:0]  fails_q;
  logic [TMR_W-1:0]   timer_q;
  logic               unlocked_q, alarm_q;

  logic [DIGIT_W-1:0] cur_digit;
  logic [ENTRY_W-1:0] entry_shift;
  logic               digit_phase, prog_abort, sel_clear, sel_en;

  assign digit_phase = (state_q == S_LOCKED) || (state_q == S_PROGRAM);
  assign prog_abort  = (state_q == S_PROGRAM) && lock_req_i;
  // The selector returns to 0 on every commit, discard, abort and compare.
  assign sel_clear   = (digit_phase && (clear_i || enter_i)) || prog_abort || (state_q == S_CHECK);
  assign sel_en      = digit_phase && !prog_abort;
  assign entry_shift = (entry_q << DIGIT_W) | ENTRY_W'(cur_digit);

  digit_selector #(.DIGIT_W(DIGIT_W)) u_digit_selector (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    (sel_en),
    .inc_i   (inc_i),
    .dec_i   (dec_i),
    .clear_i (sel_clear),
    .digit_o (cur_digit)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= S_LOCKED;
      entry_q    <= '0;
      cnt_q      <= '0;
      fails_q    <= '0;
      code_q     <= DEFAULT_CODE;
      timer_q    <= '0;
      unlocked_q <= 1'b0;
      alarm_q    <= 1'b0;
    end else begin
      case (state_q)
        S_LOCKED, S_PROGRAM: begin
          if (prog_abort) begin
            state_q <= S_LOCKED;
            entry_q <= '0;
            cnt_q   <= '0;
          end else if (clear_i) begin
            entry_q <= '0;
            cnt_q   <= '0;
          end else if (enter_i) begin
            if (cnt_q != CNT_LAST) begin
              entry_q <= entry_shift;
              cnt_q   <= cnt_q + CNT_W'(1);
            end else if (state_q == S_LOCKED) begin
              entry_q <= entry_shift;
              cnt_q   <= cnt_q + CNT_W'(1);
              state_q <= S_CHECK;
            end else begin
              code_q     <= entry_shift;
              entry_q    <= '0;
              cnt_q      <= '0;
              state_q    <= S_UNLOCKED;
              unlocked_q <= 1'b1;
            end
          end
        end
        S_CHECK: begin
          entry_q <= '0;
          cnt_q   <= '0;
          if (entry_q == code_q) begin
            state_q    <= S_UNLOCKED;
            fails_q    <= '0;
            unlocked_q <= 1'b1;
          end else if (fails_q != FAIL_LAST) begin
            state_q <= S_LOCKED;
            fails_q <= fails_q + FAIL_W'(1);
          end else begin
            state_q <= S_LOCKOUT;
            fails_q <= FAIL_MAX;
            timer_q <= TMR_INIT;
            alarm_q <= 1'b1;
          end
        end
        S_UNLOCKED: begin
          if (lock_req_i) begin
            state_q    <= S_LOCKED;
            unlocked_q <= 1'b0;
          end else if (prog_i) begin
            state_q    <= S_PROGRAM;
            entry_q    <= '0;
            cnt_q      <= '0;
            unlocked_q <= 1'b0;
          end
        end
        S_LOCKOUT: begin
          if (timer_q == '0) begin
            state_q <= S_LOCKED;
            fails_q <= '0;
            alarm_q <= 1'b0;
          end else begin
            timer_q <= timer_q - TMR_W'(1);
          end
        end
        default: begin
          state_q    <= S_LOCKED;
          unlocked_q <= 1'b0;
          alarm_q    <= 1'b0;
        end
      endcase
    end
  end

  assign cur_digit_o = cur_digit;
  assign entry_o     = entry_q;
  assign digit_cnt_o = cnt_q;
  assign fails_o     = fails_q;
  assign state_o     = state_q;
  assign unlocked_o  = unlocked_q;
  assign alarm_o     = alarm_q;

endmodule

// File: tb/tb_combo_lock_core.sv
// Directed and random stimulus for combo_lock_core, checked every cycle against
// a digit-list model of the lock rules.
module tb_combo_lock_core;

  localparam int NUM_DIGITS = 4;
  localparam int RADIX      = 16;
  localparam int MAX_TRIES  = 3;
  localparam int LOCKOUT    = 8;

  logic        clk = 1'b0;
  logic        rst_n, inc, dec, enter, clear, lock_req, prog;
  logic [3:0]  cur_digit;
  logic [15:0] entry;
  logic [2:0]  digit_cnt;
  logic [1:0]  fails;
  logic [2:0]  state;
  logic        unlocked, alarm;

  combo_lock_core #(
    .NUM_DIGITS(NUM_DIGITS), .DIGIT_W(4), .DEFAULT_CODE(16'h1234),
    .MAX_TRIES(MAX_TRIES), .LOCKOUT_CYCLES(LOCKOUT)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .inc_i(inc), .dec_i(dec), .enter_i(enter),
    .clear_i(clear), .lock_req_i(lock_req), .prog_i(prog),
    .cur_digit_o(cur_digit), .entry_o(entry), .digit_cnt_o(digit_cnt),
    .fails_o(fails), .state_o(state), .unlocked_o(unlocked), .alarm_o(alarm)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Model: 0 LOCKED, 1 CHECK, 2 UNLOCKED, 3 PROGRAM, 4 LOCKOUT
  int m_state, m_digit, m_fails, m_timer;
  int m_digits[$];
  int m_code[NUM_DIGITS];

  task automatic model_reset();
    m_state = 0; m_digit = 0; m_fails = 0; m_timer = 0;
    m_digits.delete();
    m_code[0] = 1; m_code[1] = 2; m_code[2] = 3; m_code[3] = 4;
  endtask

  function automatic int model_entry();
    int acc = 0;
    foreach (m_digits[i]) acc = acc * RADIX + m_digits[i];
    return acc;
  endfunction

  task automatic step_model(input bit i_inc, input bit i_dec, input bit i_ent,
                            input bit i_clr, input bit i_lk, input bit i_pg);
    bit match;
    case (m_state)
      0, 3: begin
        if (m_state == 3 && i_lk) begin
          m_state = 0; m_digits.delete(); m_digit = 0;
        end else if (i_clr) begin
          m_digits.delete(); m_digit = 0;
        end else if (i_ent) begin
          m_digits.push_back(m_digit);
          m_digit = 0;
          if (m_digits.size() == NUM_DIGITS) begin
            if (m_state == 0) begin
              m_state = 1;
            end else begin
              foreach (m_code[i]) m_code[i] = m_digits[i];
              m_digits.delete();
              m_state = 2;
            end
          end
        end else if (i_inc && !i_dec) begin
          m_digit = (m_digit + 1) % RADIX;
        end else if (i_dec && !i_inc) begin
          m_digit = (m_digit + RADIX - 1) % RADIX;
        end
      end
      1: begin
        match = 1'b1;
        foreach (m_code[i]) if (m_digits[i] != m_code[i]) match = 1'b0;
        m_digits.delete();
        m_digit = 0;
        if (match) begin
          m_state = 2; m_fails = 0;
        end else if (m_fails + 1 < MAX_TRIES) begin
          m_state = 0; m_fails = m_fails + 1;
        end else begin
          m_state = 4; m_fails = MAX_TRIES; m_timer = LOCKOUT - 1;
        end
      end
      2: begin
        if (i_lk) m_state = 0;
        else if (i_pg) begin m_state = 3; m_digits.delete(); end
      end
      4: begin
        if (m_timer == 0) begin m_state = 0; m_fails = 0; end
        else m_timer = m_timer - 1;
      end
      default: ;
    endcase
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  task automatic compare_all();
    check("state",     32'(state),     m_state);
    check("cur_digit", 32'(cur_digit), m_digit);
    check("entry",     32'(entry),     model_entry());
    check("digit_cnt", 32'(digit_cnt), m_digits.size());
    check("fails",     32'(fails),     m_fails);
    check("unlocked",  32'(unlocked),  (m_state == 2) ? 1 : 0);
    check("alarm",     32'(alarm),     (m_state == 4) ? 1 : 0);
  endtask

  task automatic cyc(input bit i_inc, input bit i_dec, input bit i_ent,
                     input bit i_clr, input bit i_lk, input bit i_pg);
    inc = i_inc; dec = i_dec; enter = i_ent; clear = i_clr; lock_req = i_lk; prog = i_pg;
    @(posedge clk);
    step_model(i_inc, i_dec, i_ent, i_clr, i_lk, i_pg);
    #1;
    $display("cyc inc=%0b dec=%0b ent=%0b clr=%0b lk=%0b pg=%0b -> st=%0d dig=%0h entry=%04h cnt=%0d fails=%0d",
             i_inc, i_dec, i_ent, i_clr, i_lk, i_pg, state, cur_digit, entry, digit_cnt, fails);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    inc = 0; dec = 0; enter = 0; clear = 0; lock_req = 0; prog = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_reset();
      #1;
      $display("reset cycle %0d -> st=%0d entry=%04h", k, state, entry);
      compare_all();
    end
    rst_n = 1'b1;
  endtask

  // Walk the selector to digit d by the shorter direction, then commit it.
  task automatic press(input int d);
    int diff;
    for (int g = 0; g < RADIX && m_digit != d; g++) begin
      diff = (d - m_digit + RADIX) % RADIX;
      if (diff <= RADIX / 2) cyc(1, 0, 0, 0, 0, 0);
      else cyc(0, 1, 0, 0, 0, 0);
    end
    cyc(0, 0, 1, 0, 0, 0);
  endtask

  task automatic enter_code(input int a, input int b, input int c, input int d);
    press(a); press(b); press(c); press(d);
  endtask

  initial begin
    int r;
    bit r_inc, r_dec, r_ent, r_clr, r_lk, r_pg;

    model_reset();
    do_reset(3);
    check("reset_state_literal", 32'(state), 0);

    // 1. correct code
    enter_code(1, 2, 3, 4);
    check("check_state_literal", 32'(state), 1);
    idle(1);
    check("unlocked_literal", 32'(unlocked), 1);
    cyc(0, 0, 0, 0, 1, 0);

    // 2. wrap and simultaneity
    cyc(0, 1, 0, 0, 0, 0);
    check("dec_wrap_literal", 32'(cur_digit), 15);
    cyc(1, 0, 0, 0, 0, 0);
    check("inc_wrap_literal", 32'(cur_digit), 0);
    cyc(1, 1, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0);
    check("enter_inc_lsb_literal", 32'(entry[3:0]), 5);
    cyc(0, 0, 0, 1, 0, 0);

    // 3. lockout with inputs hammered during it
    for (int t = 0; t < MAX_TRIES; t++) begin
      enter_code(0, 0, 0, 0);
      idle(1);
    end
    for (int k = 0; k < LOCKOUT; k++) cyc(1, 0, k[0], k[1], 1, 1);
    idle(2);

    // 4. program a new code
    enter_code(1, 2, 3, 4); idle(1);
    cyc(0, 0, 0, 0, 0, 1);
    enter_code(9, 8, 7, 6);
    cyc(0, 0, 0, 0, 1, 0);
    enter_code(1, 2, 3, 4); idle(1);
    enter_code(9, 8, 7, 6); idle(1);
    check("new_code_literal", 32'(unlocked), 1);
    cyc(0, 0, 0, 0, 1, 0);

    // 6a. reset mid-entry restores default code
    press(5); press(6);
    do_reset(1);
    enter_code(1, 2, 3, 4); idle(1);
    check("code_restored_literal", 32'(unlocked), 1);
    cyc(0, 0, 0, 0, 1, 0);

    // 5. clear and program abort
    press(1); press(2);
    cyc(0, 0, 0, 1, 0, 0);
    enter_code(1, 2, 3, 4); idle(1);
    cyc(0, 0, 0, 0, 0, 1);
    press(7); press(7);
    cyc(0, 0, 0, 0, 1, 0);
    enter_code(1, 2, 3, 4); idle(1);
    cyc(0, 0, 0, 0, 1, 0);

    // 6b. reset during lockout
    for (int t = 0; t < MAX_TRIES; t++) begin
      enter_code(0, 0, 0, 0);
      idle(1);
    end
    idle(3);
    do_reset(1);

    // random phase
    for (int n = 0; n < 1500; n++) begin
      if (n % 250 == 0 && m_state == 0) begin
        cyc(0, 0, 0, 1, 0, 0);
        enter_code(m_code[0], m_code[1], m_code[2], m_code[3]);
      end
      r = $urandom_range(0, 99); r_inc = (r < 35);
      r = $urandom_range(0, 99); r_dec = (r < 25);
      r = $urandom_range(0, 99); r_ent = (r < 15);
      r = $urandom_range(0, 99); r_clr = (r < 3);
      r = $urandom_range(0, 99); r_lk  = (r < 4);
      r = $urandom_range(0, 99); r_pg  = (r < 8);
      cyc(r_inc, r_dec, r_ent, r_clr, r_lk, r_pg);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/combo_lock_core.md
Name: combo_lock_core

Overview:
Parametrised successor of the board-level combo lock. It folds the digit selector, the shift-in entry register, the digit counter and the lock state machine into one synchronous core. It adds a configurable code length and digit width, a user-programmable code, a failed-attempt counter and a timed lockout. It sits between the debounced single-cycle button pulses and the seven-segment and LED drivers.

Parameters:
NUM_DIGITS, 4, digits per code (≥1)
DIGIT_W, 4, bits per digit; digit range 0..2^DIGIT_W-1
DEFAULT_CODE, 16'h1234, code loaded at reset (NUM_DIGITS*DIGIT_W bits)
MAX_TRIES, 3, consecutive wrong codes that trigger lockout (≥1)
LOCKOUT_CYCLES, 100_000_000, clk cycles spent in lockout (≥1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-low reset
inc  in  1  single-cycle pulse: cur_digit +1
dec  in  1  single-cycle pulse: cur_digit -1
enter  in  1  single-cycle pulse: commit cur_digit
clear  in  1  single-cycle pulse: discard partial entry
lock_req  in  1  single-cycle pulse: relock from UNLOCKED
prog  in  1  single-cycle pulse: enter PROGRAM from UNLOCKED
cur_digit  out  DIGIT_W  digit currently selected
entry  out  NUM_DIGITS*DIGIT_W  digits committed so far; newest in LSBs
digit_cnt  out  $clog2(NUM_DIGITS+1)  number of committed digits
fails  out  $clog2(MAX_TRIES+1)  consecutive failed attempts
state  out  3  current FSM state encoding
unlocked  out  1  high only in UNLOCKED
alarm  out  1  high only in LOCKOUT

Behaviour:
- Reset (rst==0 at clk edge):
  - state=LOCKED; cur_digit, entry, digit_cnt and fails = 0; code register = DEFAULT_CODE; lockout timer = 0; unlocked and alarm = 0.
  - Reset mid-entry, mid-program or mid-lockout aborts the operation; a code programmed before reset is lost.
- All outputs are registered.
- States: LOCKED=0, CHECK=1, UNLOCKED=2, PROGRAM=3, LOCKOUT=4.
- Digit selector (LOCKED and PROGRAM only):
  - inc alone gives +1 mod 2^DIGIT_W; dec alone gives -1 mod 2^DIGIT_W, so 0 wraps to max and max wraps to 0.
  - inc and dec together: no change.
- Input priority per cycle: clear > enter > inc/dec.
  - clear: entry=0, digit_cnt=0, cur_digit=0.
  - enter: entry shifts left by DIGIT_W with cur_digit inserted into the LSBs; digit_cnt +1; cur_digit=0. An inc or dec in the same cycle is dropped, and the pre-edit cur_digit is committed.
- LOCKED:
  - An enter that makes digit_cnt==NUM_DIGITS moves to CHECK on the next edge.
- CHECK (exactly 1 cycle): compare entry with the code register, then clear entry, digit_cnt and cur_digit.
  - Match → UNLOCKED, fails=0.
  - Mismatch with fails+1 < MAX_TRIES → LOCKED, fails+1.
  - Mismatch with fails+1 == MAX_TRIES → LOCKOUT, fails=MAX_TRIES, timer=LOCKOUT_CYCLES-1.
  - All inputs are ignored in CHECK.
- UNLOCKED:
  - lock_req → LOCKED.
  - prog → PROGRAM, with entry and digit_cnt cleared.
  - lock_req together with prog: lock_req wins.
  - Digit inputs are ignored.
- PROGRAM:
  - Digit entry works as in LOCKED.
  - The enter that completes NUM_DIGITS digits writes the full new entry value into the code register and returns to UNLOCKED on the same edge; entry and digit_cnt are cleared.
  - lock_req aborts: the code is unchanged, state → LOCKED.
- LOCKOUT:
  - All inputs are ignored; the timer decrements each cycle.
  - When timer==0, state → LOCKED and fails=0.
  - Lockout duration is exactly LOCKOUT_CYCLES cycles with alarm high.
- Latency from the final enter edge:
  - LOCKED path: unlocked rises 2 edges later (via CHECK).
  - PROGRAM path: the code update is visible 1 edge later.

Decomposition:
- Package combo_lock_pkg holds:
  - the state encoding localparams (LOCKED..LOCKOUT) and the 3-bit state width;
  - a helper function for the width of digit_cnt and fails.
- Sub-module digit_selector, parametrised by DIGIT_W, handles the wrap-around inc/dec counter with a synchronous clear. The core asserts that clear on every enter and clear pulse.
- The FSM, entry shift register, code register and timer stay in combo_lock_core.

Test Plan (NUM_DIGITS=4, DIGIT_W=4, DEFAULT_CODE=16'h1234, MAX_TRIES=3, LOCKOUT_CYCLES=8):
1. Correct code: enter the digits 1, 2, 3 and 4 in order → CHECK for 1 cycle, then unlocked=1, fails=0, entry=0, state=2.
2. Wrap and simultaneity:
   - dec from 0 → cur_digit=F;
   - inc from F → 0;
   - inc with dec → unchanged;
   - enter with inc at cur_digit=5 → entry LSBs=5, cur_digit=0.
3. Lockout:
   - wrong code 0000 three times → fails goes 1, then 2, then 3;
   - state=LOCKOUT and alarm=1 for exactly 8 cycles;
   - inputs during lockout have no effect;
   - then state=LOCKED and fails=0.
4. Program:
   - unlock with 1234, pulse prog, enter 9, 8, 7 and 6 → UNLOCKED;
   - lock_req, then 1234 → fail;
   - 9876 → unlocked.
5. Clear and abort:
   - enter 1 and 2, clear, then 1, 2, 3 and 4 → unlocked;
   - in PROGRAM, enter 2 digits, then lock_req → LOCKED with the code still 1234.
6. Reset mid-operation: drive rst low after 2 digits or during lockout → all outputs at their reset values, and the code returns to 1234 even after a reprogram.
